// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU memory-mapped bus master.
// Holds the FSM state encoding, BRAM select codes and bus field widths.
package cpu_bus_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 16;

  localparam logic [1:0] BRAM_SELECT_CONTROLLER = 2'd0;
  localparam logic [1:0] BRAM_SELECT_MOD        = 2'd1;
  localparam logic [1:0] BRAM_SELECT_NORMAL     = 2'd2;
  localparam logic [1:0] BRAM_SELECT_STM        = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } bus_state_t;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cpu_bus_master.sv
// Valid/ready request stream to CPU bus cycles (setup/strobe/hold/turn), all bus outputs registered.
// Latency: write accept->WE0_N low 1+SETUP, read accept->RSP_VALID 1+SETUP+STROBE; REQ_READY only in IDLE.
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int TURN_CYCLES   = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [1:0]            REQ_SELECT,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic [15:0]           CPU_ADDR,
  output logic [DATA_WIDTH-1:0] CPU_DATA_O,
  output logic                  CPU_DATA_OE,
  input  logic [DATA_WIDTH-1:0] CPU_DATA_I,
  output logic                  CPU_CS1_N,
  output logic                  CPU_WE0_N,
  output logic                  CPU_RD_N,
  output logic                  CPU_RDWR,
  output logic                  BUSY
);

  localparam int MAX_CYCLES = max_of4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, TURN_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam bit               HAS_HOLD    = (HOLD_CYCLES > 0);
  localparam bit               HAS_TURN    = (TURN_CYCLES > 0);

  bus_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  cs_n_q, cs_n_d;
  logic                  we_n_q, we_n_d;
  logic                  rd_n_q, rd_n_d;
  logic                  rdwr_q, rdwr_d;
  logic [15:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_o_q, data_o_d;
  logic                  data_oe_q, data_oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  cnt_done;
  bus_state_t            after_hold;

  assign cnt_done = (cnt_q == '0);
  // rdwr_q doubles as the latched direction: only reads pass through TURN.
  assign after_hold = (rdwr_q && HAS_TURN) ? TURN : IDLE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    we_n_d      = we_n_q;
    rd_n_d      = rd_n_q;
    rdwr_d      = rdwr_q;
    addr_d      = addr_q;
    data_o_d    = data_o_q;
    data_oe_d   = data_oe_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (REQ_VALID && ready_q) begin
          state_d   = SETUP;
          cnt_d     = SETUP_LOAD;
          addr_d    = {REQ_SELECT, REQ_ADDR};
          data_o_d  = REQ_WDATA;
          rdwr_d    = ~REQ_WRITE;
          data_oe_d = REQ_WRITE;
          cs_n_d    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
          we_n_d  = rdwr_q;
          rd_n_d  = ~rdwr_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_done) begin
          we_n_d = 1'b1;
          rd_n_d = 1'b1;
          if (rdwr_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = CPU_DATA_I;
          end
          if (HAS_HOLD) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d   = after_hold;
            cnt_d     = TURN_LOAD;
            cs_n_d    = 1'b1;
            data_oe_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d   = after_hold;
          cnt_d     = TURN_LOAD;
          cs_n_d    = 1'b1;
          data_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      rdwr_q      <= 1'b1;
      addr_q      <= '0;
      data_o_q    <= '0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      rd_n_q      <= rd_n_d;
      rdwr_q      <= rdwr_d;
      addr_q      <= addr_d;
      data_o_q    <= data_o_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign REQ_READY   = ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign CPU_ADDR    = addr_q;
  assign CPU_DATA_O  = data_o_q;
  assign CPU_DATA_OE = data_oe_q;
  assign CPU_CS1_N   = cs_n_q;
  assign CPU_WE0_N   = we_n_q;
  assign CPU_RD_N    = rd_n_q;
  assign CPU_RDWR    = rdwr_q;
  assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: default-timing instance u0 and a SETUP=2/STROBE=3/HOLD=0/TURN=2 instance u1.
// Per-cycle output traces (bit n = cycle n after the accept cycle 0) are compared against hand-derived vectors.
module tb_cpu_bus_master;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dut_sel;
  logic        req_valid, req_write;
  logic [1:0]  req_select;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] data_i;

  logic        rdy0, rspv0, oe0, cs0, we0, rd0, rw0, busy0;
  logic [15:0] rdat0, addr0, do0;
  logic        rdy1, rspv1, oe1, cs1, we1, rd1, rw1, busy1;
  logic [15:0] rdat1, addr1, do1;

  logic        o_rdy, o_rspv, o_oe, o_cs, o_we, o_rd, o_rw, o_busy;
  logic [15:0] o_rdat, o_addr, o_do;

  int checks = 0;
  int errors = 0;

  logic [31:0] v_cs, v_we, v_rd, v_oe, v_busy, v_rdy, v_rsp;
  logic [15:0] a_log [12];
  logic [15:0] d_log [12];
  logic        rw_log [12];
  logic [15:0] rsp_dat;
  int          clash;

  always #5 clk = ~clk;

  cpu_bus_master u0 (
    .CLK(clk), .RESET_N(rst_n),
    .REQ_VALID(req_valid & ~dut_sel), .REQ_READY(rdy0), .REQ_WRITE(req_write),
    .REQ_SELECT(req_select), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rspv0), .RSP_RDATA(rdat0),
    .CPU_ADDR(addr0), .CPU_DATA_O(do0), .CPU_DATA_OE(oe0), .CPU_DATA_I(data_i),
    .CPU_CS1_N(cs0), .CPU_WE0_N(we0), .CPU_RD_N(rd0), .CPU_RDWR(rw0), .BUSY(busy0)
  );

  cpu_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(0), .TURN_CYCLES(2)) u1 (
    .CLK(clk), .RESET_N(rst_n),
    .REQ_VALID(req_valid & dut_sel), .REQ_READY(rdy1), .REQ_WRITE(req_write),
    .REQ_SELECT(req_select), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rspv1), .RSP_RDATA(rdat1),
    .CPU_ADDR(addr1), .CPU_DATA_O(do1), .CPU_DATA_OE(oe1), .CPU_DATA_I(data_i),
    .CPU_CS1_N(cs1), .CPU_WE0_N(we1), .CPU_RD_N(rd1), .CPU_RDWR(rw1), .BUSY(busy1)
  );

  assign o_rdy  = dut_sel ? rdy1  : rdy0;
  assign o_rspv = dut_sel ? rspv1 : rspv0;
  assign o_rdat = dut_sel ? rdat1 : rdat0;
  assign o_addr = dut_sel ? addr1 : addr0;
  assign o_do   = dut_sel ? do1   : do0;
  assign o_oe   = dut_sel ? oe1   : oe0;
  assign o_cs   = dut_sel ? cs1   : cs0;
  assign o_we   = dut_sel ? we1   : we0;
  assign o_rd   = dut_sel ? rd1   : rd0;
  assign o_rw   = dut_sel ? rw1   : rw0;
  assign o_busy = dut_sel ? busy1 : busy0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs1_n"}, 32'(o_cs), 1);
    chk({tag, "_we0_n"}, 32'(o_we), 1);
    chk({tag, "_rd_n"},  32'(o_rd), 1);
    chk({tag, "_rdwr"},  32'(o_rw), 1);
    chk({tag, "_addr"},  32'(o_addr), 0);
    chk({tag, "_data_o"}, 32'(o_do), 0);
    chk({tag, "_oe"},    32'(o_oe), 0);
    chk({tag, "_ready"}, 32'(o_rdy), 0);
    chk({tag, "_rspv"},  32'(o_rspv), 0);
    chk({tag, "_rdata"}, 32'(o_rdat), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
  endtask

  // Runs 12 cycles from the accept cycle; a simple slave drives data_i while RD_N is low.
  task automatic run(input bit vary, input logic [15:0] base, input int n_req,
                     input logic [1:0] s2, input logic [13:0] a2, input logic w2);
    int acc;
    bit hs;
    acc = 0;
    v_cs = '0; v_we = '0; v_rd = '0; v_oe = '0; v_busy = '0; v_rdy = '0; v_rsp = '0;
    rsp_dat = '0;
    clash = 0;
    for (int c = 0; c < 12; c++) begin
      v_cs[c] = o_cs; v_we[c] = o_we; v_rd[c] = o_rd; v_oe[c] = o_oe;
      v_busy[c] = o_busy; v_rdy[c] = o_rdy; v_rsp[c] = o_rspv;
      a_log[c] = o_addr; d_log[c] = o_do; rw_log[c] = o_rw;
      if (o_rspv) rsp_dat = o_rdat;
      if (o_oe && !o_rd) clash++;
      data_i = !o_rd ? (vary ? base + 16'(c) : base) : 16'hDEAD;
      hs = req_valid && o_rdy;
      tick();
      if (hs) begin
        acc++;
        if (acc < n_req) begin
          req_select = s2; req_addr = a2; req_write = w2; req_wdata = 16'h0F0F;
        end else begin
          req_valid  = 1'b0;
          req_select = ~req_select; req_addr = ~req_addr;
          req_wdata  = ~req_wdata;  req_write = ~req_write;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rsp_seen;
    rst_n = 1'b0; dut_sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_select = '0; req_addr = '0; req_wdata = '0; data_i = 16'hDEAD;
    tick(); tick();
    chk_reset("rst_u0");
    dut_sel = 1'b1;
    chk_reset("rst_u1");
    dut_sel = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready_u0", 32'(rdy0), 1);
    chk("post_rst_ready_u1", 32'(rdy1), 1);

    // Single write, default timing; fields are scrambled right after accept.
    req_valid = 1'b1; req_write = 1'b1; req_select = BRAM_SELECT_CONTROLLER;
    req_addr = 14'h0020; req_wdata = 16'hA5A5;
    run(1'b0, 16'h0, 1, 2'd0, 14'h0, 1'b0);
    chk("wr_cs1_n", v_cs,   32'b111111100001);
    chk("wr_we0_n", v_we,   32'b111111110011);
    chk("wr_rd_n",  v_rd,   32'b111111111111);
    chk("wr_oe",    v_oe,   32'b000000011110);
    chk("wr_busy",  v_busy, 32'b000000011110);
    chk("wr_ready", v_rdy,  32'b111111100001);
    chk("wr_rspv",  v_rsp,  32'b0);
    chk("wr_addr",  32'(a_log[1]), 32'h0020);
    chk("wr_addr_held", 32'(a_log[11]), 32'h0020);
    chk("wr_data_o", 32'(d_log[2]), 32'hA5A5);
    chk("wr_data_o_hold", 32'(d_log[4]), 32'hA5A5);
    chk("wr_rdwr",  32'(rw_log[1]), 0);

    // Single read, default timing.
    req_valid = 1'b1; req_write = 1'b0; req_select = BRAM_SELECT_NORMAL;
    req_addr = 14'h0003; req_wdata = 16'h0000;
    run(1'b0, 16'h1234, 1, 2'd0, 14'h0, 1'b0);
    chk("rd_cs1_n", v_cs,   32'b111111100001);
    chk("rd_rd_n",  v_rd,   32'b111111110011);
    chk("rd_we0_n", v_we,   32'b111111111111);
    chk("rd_oe",    v_oe,   32'b0);
    chk("rd_busy",  v_busy, 32'b000000111110);
    chk("rd_ready", v_rdy,  32'b111111000001);
    chk("rd_rspv",  v_rsp,  32'b000000010000);
    chk("rd_rdata", 32'(rsp_dat), 32'h1234);
    chk("rd_addr",  32'(a_log[2]), 32'h8003);
    chk("rd_rdwr",  32'(rw_log[1]), 1);
    chk("rd_oe_clash", clash, 0);

    // Back-to-back write then read with VALID held; data_i varies per cycle to pin the sample point.
    req_valid = 1'b1; req_write = 1'b1; req_select = BRAM_SELECT_CONTROLLER;
    req_addr = 14'h0010; req_wdata = 16'h5A5A;
    run(1'b1, 16'hC000, 2, BRAM_SELECT_MOD, 14'h0155, 1'b0);
    chk("b2b_cs1_n", v_cs,   32'b110000100001);
    chk("b2b_we0_n", v_we,   32'b111111110011);
    chk("b2b_rd_n",  v_rd,   32'b111001111111);
    chk("b2b_oe",    v_oe,   32'b000000011110);
    chk("b2b_busy",  v_busy, 32'b011111011110);
    chk("b2b_ready", v_rdy,  32'b100000100001);
    chk("b2b_rspv",  v_rsp,  32'b001000000000);
    chk("b2b_rdata", 32'(rsp_dat), 32'hC008);
    chk("b2b_addr1", 32'(a_log[3]), 32'h0010);
    chk("b2b_addr2", 32'(a_log[6]), 32'h4155);
    chk("b2b_rdwr2", 32'(rw_log[6]), 1);
    chk("b2b_oe_clash", clash, 0);

    // Read on the SETUP=2 STROBE=3 HOLD=0 TURN=2 instance.
    dut_sel = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_select = BRAM_SELECT_STM;
    req_addr = 14'h1FFF; req_wdata = 16'h0000;
    run(1'b1, 16'hC000, 1, 2'd0, 14'h0, 1'b0);
    chk("p_cs1_n", v_cs,   32'b111111000001);
    chk("p_rd_n",  v_rd,   32'b111111000111);
    chk("p_we0_n", v_we,   32'b111111111111);
    chk("p_oe",    v_oe,   32'b0);
    chk("p_busy",  v_busy, 32'b000011111110);
    chk("p_ready", v_rdy,  32'b111100000001);
    chk("p_rspv",  v_rsp,  32'b000001000000);
    chk("p_rdata", 32'(rsp_dat), 32'hC005);
    chk("p_addr",  32'(a_log[1]), 32'hDFFF);

    // Reset asserted during the strobe of a read on u0.
    dut_sel = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_select = BRAM_SELECT_STM;
    req_addr = 14'h0AAA; data_i = 16'h7777;
    chk("mr_ready", 32'(o_rdy), 1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("mr_rd_low", 32'(o_rd), 0);
    rst_n = 1'b0;
    #1;
    chk_reset("mr");
    tick();
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_rspv) rsp_seen++;
    end
    chk("mr_no_rsp", rsp_seen, 0);
    chk("mr_rdata", 32'(o_rdat), 0);
    chk("mr_ready_again", 32'(o_rdy), 1);

    req_valid = 1'b1; req_write = 1'b0; req_select = BRAM_SELECT_NORMAL;
    req_addr = 14'h0003;
    run(1'b0, 16'h1234, 1, 2'd0, 14'h0, 1'b0);
    chk("mr2_cs1_n", v_cs,  32'b111111100001);
    chk("mr2_rd_n",  v_rd,  32'b111111110011);
    chk("mr2_rspv",  v_rsp, 32'b000000010000);
    chk("mr2_rdata", 32'(rsp_dat), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
